// File: rtl/full_adder_pkg.sv
// Shared definitions for the registered full adder: default width and the
// carry-in source selector.
package full_adder_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

  // Where the effective carry-in of an operation comes from.
  typedef enum logic {
    CIN_PORT  = 1'b0,
    CIN_CHAIN = 1'b1
  } cin_sel_e;

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder; the ripple element of full_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder with optional carry chaining across operations.
// Define FULL_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             carry_chain,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] y,
  output logic             x,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Combinational result of one add, sized by this instance's WIDTH.
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } fa_result_t;

  // Handshake: in_valid has no back-pressure; every edge with in_valid=1 and
  // rst=0 accepts an operation, and out_valid pulses for exactly the cycle
  // after each accepted operation.
  cin_sel_e         cin_sel;
  logic             cin_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  fa_result_t       result;

  assign cin_sel = carry_chain ? CIN_CHAIN : CIN_PORT;
  assign cin_eff = (cin_sel == CIN_CHAIN) ? x : carry_in;
  assign carry[0] = cin_eff;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign result.carry = carry[WIDTH];
  assign result.sum   = sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      x         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= result.sum;
        x <= result.carry;
      end
    end
  end

`ifdef FULL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= carry[WIDTH-1] ^ carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder: a WIDTH=1 and a WIDTH=8
// instance share clock and reset; each step drives, clocks, then checks.
module tb_full_adder;

  logic clk;
  logic rst;

  logic       v1, ch1, ci1, a1, b1;
  logic       y1, x1, ov1;
  logic       v8, ch8, ci8;
  logic [7:0] a8, b8, y8;
  logic       x8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst (rst), .in_valid (v1), .carry_chain (ch1),
    .a (a1), .b (b1), .carry_in (ci1),
    .y (y1), .x (x1), .out_valid (ov1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf (ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .in_valid (v8), .carry_chain (ch8),
    .a (a8), .b (b8), .carry_in (ci8),
    .y (y8), .x (x8), .out_valid (ov8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf (ovf8)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: drive, take one edge, leave #1 so checks sample after it.
  task automatic op1(input logic v, input logic ch, input logic a, input logic b, input logic ci);
    v1 = v; ch1 = ch; a1 = a; b1 = b; ci1 = ci;
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic v, input logic ch, input logic [7:0] a, input logic [7:0] b,
                     input logic ci);
    v8 = v; ch8 = ch; a8 = a; b8 = b; ci8 = ci;
    @(posedge clk); #1;
  endtask

  task automatic expect1(input string tag, input logic ey, input logic ex, input logic ev);
    check({tag, ".y"}, {8'd0, y1}, {8'd0, ey});
    check({tag, ".x"}, {8'd0, x1}, {8'd0, ex});
    check({tag, ".valid"}, {8'd0, ov1}, {8'd0, ev});
  endtask

  task automatic expect8(input string tag, input logic [7:0] ey, input logic ex, input logic eo);
    check({tag, ".y"}, {1'b0, y8}, {1'b0, ey});
    check({tag, ".x"}, {8'd0, x8}, {8'd0, ex});
    check({tag, ".valid"}, {8'd0, ov8}, 9'd1);
`ifdef FULL_ADDER_OVF_EN
    check({tag, ".ovf"}, {8'd0, ovf8}, {8'd0, eo});
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  // Hand-computed {x,y} and signed overflow for {a,b,carry_in} = 0..7.
  logic [1:0] tt_sum [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  logic       tt_ovf [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    v1 = 1'b1; ch1 = 1'b0; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b0;
    v8 = 1'b1; ch8 = 1'b0; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;

    // Reset overrides in_valid for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      expect1("rst1", 1'b0, 1'b0, 1'b0);
      check("rst8.y", {1'b0, y8}, 9'd0);
      check("rst8.valid", {8'd0, ov8}, 9'd0);
    end
    rst = 1'b0;
    v8 = 1'b0;
    op1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect1("post_rst_idle", 1'b0, 1'b0, 1'b0);

    // Single-bit truth table, external carry.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      op1(1'b1, 1'b0, abc[2], abc[1], abc[0]);
      expect1($sformatf("tt%0d", i), tt_sum[i][0], tt_sum[i][1], 1'b1);
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("tt%0d.ovf", i), {8'd0, ovf1}, {8'd0, tt_ovf[i]});
`endif
    end

    // Chained sequence; carry_in held at 1 while chaining to show it is ignored.
    op1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); expect1("chain0", 1'b0, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); expect1("chain1", 1'b0, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1); expect1("chain2", 1'b0, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect1("chain3", 1'b1, 1'b0, 1'b1);
    op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); expect1("chain4", 1'b0, 1'b1, 1'b1);

    // Idle cycles hold y/x; the next chained op still sees x=1.
    for (int i = 0; i < 3; i++) begin
      op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      expect1($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b0);
    end
    op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); expect1("idle_resume", 1'b1, 1'b0, 1'b1);

    // Reset mid-chain clears the carry.
    op1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); expect1("pre_rst", 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    op1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); expect1("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    op1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); expect1("after_rst", 1'b1, 1'b0, 1'b1);
    v1 = 1'b0;

    // Multi-bit vectors on the 8-bit instance.
    op8(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0); expect8("w8_ff_01", 8'h00, 1'b1, 1'b0);
    op8(1'b1, 1'b0, 8'h7F, 8'h00, 1'b1); expect8("w8_7f_00_1", 8'h80, 1'b0, 1'b1);
    op8(1'b1, 1'b0, 8'h80, 8'h80, 1'b0); expect8("w8_80_80", 8'h00, 1'b1, 1'b1);
    op8(1'b1, 1'b0, 8'h00, 8'h00, 1'b0); expect8("w8_zero", 8'h00, 1'b0, 1'b0);
    op8(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1); expect8("w8_max", 8'hFF, 1'b1, 1'b0);
    op8(1'b1, 1'b1, 8'h00, 8'h00, 1'b0); expect8("w8_chain", 8'h01, 1'b0, 1'b0);
    op8(1'b1, 1'b0, 8'h12, 8'h34, 1'b1); expect8("w8_mixed", 8'h47, 1'b0, 1'b0);
    op8(1'b0, 1'b0, 8'hAA, 8'h55, 1'b1);
    check("w8_idle.y", {1'b0, y8}, 9'h47);
    check("w8_idle.valid", {8'd0, ov8}, 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
